// File: rtl/jtu_pkg.sv
// Shared types and default sizes for the jump target unit.
package jtu_pkg;

   typedef enum logic [2:0] {
      SEQ  = 3'd0,
      JABS = 3'd1,
      JLBL = 3'd2,
      BREL = 3'd3,
      CALL = 3'd4,
      RET  = 3'd5
   } jtu_mode_e;

   localparam int JTU_PC_W      = 16;
   localparam int JTU_DEPTH     = 16;
   localparam int JTU_RAS_DEPTH = 4;

endpackage

// File: rtl/jtu_ras.sv
// Return-address stack: LIFO of PC_W-wide entries with full/empty status.
module jtu_ras #(
   parameter int PC_W      = 16,
   parameter int RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  logic            pop,
   input  logic [PC_W-1:0] push_data,
   output logic [PC_W-1:0] top_data,
   output logic            full,
   output logic            empty
);

   localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);

   logic [PC_W-1:0]  stack_reg [RAS_DEPTH];
   logic [CNT_W-1:0] count_reg;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   assign wr_ptr   = PTR_W'(count_reg);
   assign rd_ptr   = PTR_W'(count_reg - 1'b1);
   assign full     = (count_reg == CNT_W'(RAS_DEPTH));
   assign empty    = (count_reg == '0);
   assign top_data = empty ? '0 : stack_reg[rd_ptr];

   // Only the occupancy count is reset; entry contents are dead once the count drops.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= '0;
      end else if (push && !full) begin
         count_reg <= count_reg + 1'b1;
      end else if (pop && !empty) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < RAS_DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (push && !full && (wr_ptr == PTR_W'(gi))) begin
               stack_reg[gi] <= push_data;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/jump_target_unit.sv
// Next-PC generator: PC register, writable label table, next-pc mux and return-address stack.
module jump_target_unit
   import jtu_pkg::*;
#(
   parameter int          PC_W      = JTU_PC_W,
   parameter int          DEPTH     = JTU_DEPTH,
   parameter int          RAS_DEPTH = JTU_RAS_DEPTH,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic [2:0]       mode,
   input  logic [PC_W-1:0]  abs_target,
   input  logic [IDX_W-1:0] label_idx,
   input  logic [PC_W-1:0]  rel_offset,
   input  logic             cond,
   input  logic             lbl_we,
   input  logic [IDX_W-1:0] lbl_waddr,
   input  logic [PC_W-1:0]  lbl_wdata,
   output logic [PC_W-1:0]  pc,
   output logic             taken,
   output logic             ras_overflow,
   output logic             ras_underflow
);

   logic [PC_W-1:0] tbl_reg [DEPTH];
   logic [PC_W-1:0] pc_reg, pc_next;
   logic            taken_reg, taken_next;
   logic            ovf_reg, unf_reg;
   logic            ovf_set, unf_set;
   logic            push, pop;
   logic            ras_full, ras_empty;
   logic [PC_W-1:0] ras_top;
   logic [PC_W-1:0] tbl_rd;
   logic            idx_valid, waddr_valid;
   jtu_mode_e       mode_e;

   assign mode_e      = jtu_mode_e'(mode);
   assign idx_valid   = (32'(label_idx) < DEPTH);
   assign waddr_valid = (32'(lbl_waddr) < DEPTH);

   // Write-first lookup so a label written this cycle can be jumped to in the same cycle.
   assign tbl_rd = (lbl_we && waddr_valid && (lbl_waddr == label_idx)) ? lbl_wdata
                 : (idx_valid ? tbl_reg[label_idx] : '0);

   always_comb begin
      pc_next    = pc_reg + 1'b1;
      taken_next = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;
      ovf_set    = 1'b0;
      unf_set    = 1'b0;
      case (mode_e)
         JABS: begin
            pc_next    = abs_target;
            taken_next = 1'b1;
         end
         JLBL: begin
            if (idx_valid) begin
               pc_next    = tbl_rd;
               taken_next = 1'b1;
            end
         end
         BREL: begin
            if (cond) begin
               pc_next    = pc_reg + rel_offset;
               taken_next = 1'b1;
            end
         end
         CALL: begin
            if (idx_valid) begin
               pc_next    = tbl_rd;
               taken_next = 1'b1;
               if (ras_full) ovf_set = 1'b1;
               else          push    = 1'b1;
            end
         end
         RET: begin
            if (!ras_empty) begin
               pc_next    = ras_top;
               taken_next = 1'b1;
               pop        = 1'b1;
            end else begin
               unf_set = 1'b1;
            end
         end
         default: ;
      endcase
   end

   jtu_ras #(
      .PC_W      (PC_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (push && !stall),
      .pop       (pop && !stall),
      .push_data (pc_reg + 1'b1),
      .top_data  (ras_top),
      .full      (ras_full),
      .empty     (ras_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_reg    <= RESET_PC;
         taken_reg <= 1'b0;
         ovf_reg   <= 1'b0;
         unf_reg   <= 1'b0;
      end else if (!stall) begin
         pc_reg    <= pc_next;
         taken_reg <= taken_next;
         ovf_reg   <= ovf_reg | ovf_set;
         unf_reg   <= unf_reg | unf_set;
      end
   end

   // Table writes proceed regardless of stall.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_tbl
         always_ff @(posedge clk) begin
            if (reset) begin
               tbl_reg[gi] <= '0;
            end else if (lbl_we && (lbl_waddr == IDX_W'(gi))) begin
               tbl_reg[gi] <= lbl_wdata;
            end
         end
      end
   endgenerate

   assign pc            = pc_reg;
   assign taken         = taken_reg;
   assign ras_overflow  = ovf_reg;
   assign ras_underflow = unf_reg;

endmodule

// File: tb/tb_jump_target_unit.sv
// Directed self-checking bench for jump_target_unit with hand-computed expectations.
module tb_jump_target_unit;
   import jtu_pkg::*;

   logic        clk = 1'b0;
   logic        reset, stall, cond, lbl_we;
   logic [2:0]  mode;
   logic [15:0] abs_target, rel_offset, lbl_wdata;
   logic [3:0]  label_idx, lbl_waddr;
   logic [15:0] pc;
   logic        taken, ras_overflow, ras_underflow;

   int n_assert = 0;
   int n_fail   = 0;

   jump_target_unit #(
      .PC_W      (16),
      .DEPTH     (16),
      .RAS_DEPTH (4),
      .RESET_PC  (16'h0000)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .mode          (mode),
      .abs_target    (abs_target),
      .label_idx     (label_idx),
      .rel_offset    (rel_offset),
      .cond          (cond),
      .lbl_we        (lbl_we),
      .lbl_waddr     (lbl_waddr),
      .lbl_wdata     (lbl_wdata),
      .pc            (pc),
      .taken         (taken),
      .ras_overflow  (ras_overflow),
      .ras_underflow (ras_underflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_pc(input string tag, input logic [15:0] exp_pc, input logic exp_taken);
      chk({tag, ".pc"}, 32'(pc), 32'(exp_pc));
      chk({tag, ".taken"}, 32'(taken), 32'(exp_taken));
      $display("step %-10s pc=%h taken=%b ovf=%b unf=%b", tag, pc, taken, ras_overflow, ras_underflow);
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; cond = 1'b0; lbl_we = 1'b0;
      mode = SEQ; abs_target = '0; rel_offset = '0; lbl_wdata = '0;
      label_idx = '0; lbl_waddr = '0;
      tick(); tick();
      reset = 1'b0;
      chk_pc("reset", 16'h0000, 1'b0);
      chk("reset.ovf", 32'(ras_overflow), 32'd0);
      chk("reset.unf", 32'(ras_underflow), 32'd0);

      // Sequential fetch
      mode = SEQ;
      tick(); chk_pc("seq1", 16'd1, 1'b0);
      tick(); chk_pc("seq2", 16'd2, 1'b0);
      tick(); chk_pc("seq3", 16'd3, 1'b0);

      // Label table write, then jump; then same-cycle write-first jump
      lbl_we = 1'b1; lbl_waddr = 4'd2; lbl_wdata = 16'd76;
      tick(); chk_pc("wr2", 16'd4, 1'b0);
      lbl_we = 1'b0; mode = JLBL; label_idx = 4'd2;
      tick(); chk_pc("jlbl2", 16'd76, 1'b1);
      lbl_we = 1'b1; lbl_waddr = 4'd3; lbl_wdata = 16'd101; label_idx = 4'd3;
      tick(); chk_pc("jlbl3wf", 16'd101, 1'b1);
      lbl_we = 1'b0;

      // Relative branch and wrap
      mode = JABS; abs_target = 16'd10;
      tick(); chk_pc("jabs10", 16'd10, 1'b1);
      mode = BREL; rel_offset = 16'hFFFB; cond = 1'b1;
      tick(); chk_pc("brel_t", 16'd5, 1'b1);
      mode = JABS; abs_target = 16'd10;
      tick(); chk_pc("jabs10b", 16'd10, 1'b1);
      mode = BREL; cond = 1'b0;
      tick(); chk_pc("brel_nt", 16'd11, 1'b0);
      mode = JABS; abs_target = 16'hFFFF;
      tick(); chk_pc("jabsffff", 16'hFFFF, 1'b1);
      mode = SEQ;
      tick(); chk_pc("seqwrap", 16'h0000, 1'b0);
      mode = BREL; rel_offset = 16'hFFFF; cond = 1'b1;
      tick(); chk_pc("brelwrap", 16'hFFFF, 1'b1);
      cond = 1'b0;

      // Call / return / underflow
      mode = JABS; abs_target = 16'd40;
      lbl_we = 1'b1; lbl_waddr = 4'd1; lbl_wdata = 16'd19;
      tick(); chk_pc("jabs40", 16'd40, 1'b1);
      lbl_we = 1'b0; mode = CALL; label_idx = 4'd1;
      tick(); chk_pc("call1", 16'd19, 1'b1);
      mode = RET;
      tick(); chk_pc("ret1", 16'd41, 1'b1);
      chk("ret1.unf", 32'(ras_underflow), 32'd0);
      tick(); chk_pc("ret_empty", 16'd42, 1'b0);
      chk("ret_empty.unf", 32'(ras_underflow), 32'd1);
      mode = SEQ;
      tick(); chk_pc("seq43", 16'd43, 1'b0);
      chk("sticky.unf", 32'(ras_underflow), 32'd1);
      chk("sticky.ovf", 32'(ras_overflow), 32'd0);

      // Five nested calls into a 4-deep RAS, labels written in the same cycle
      mode = JABS; abs_target = 16'h1000;
      tick(); chk_pc("jabs1000", 16'h1000, 1'b1);
      mode = CALL; lbl_we = 1'b1;
      label_idx = 4'd4; lbl_waddr = 4'd4; lbl_wdata = 16'd100;
      tick(); chk_pc("callA", 16'd100, 1'b1);
      label_idx = 4'd5; lbl_waddr = 4'd5; lbl_wdata = 16'd200;
      tick(); chk_pc("callB", 16'd200, 1'b1);
      label_idx = 4'd6; lbl_waddr = 4'd6; lbl_wdata = 16'd300;
      tick(); chk_pc("callC", 16'd300, 1'b1);
      label_idx = 4'd7; lbl_waddr = 4'd7; lbl_wdata = 16'd400;
      tick(); chk_pc("callD", 16'd400, 1'b1);
      chk("callD.ovf", 32'(ras_overflow), 32'd0);
      label_idx = 4'd8; lbl_waddr = 4'd8; lbl_wdata = 16'd500;
      tick(); chk_pc("callE", 16'd500, 1'b1);
      chk("callE.ovf", 32'(ras_overflow), 32'd1);
      lbl_we = 1'b0; mode = RET;
      tick(); chk_pc("retD", 16'd301, 1'b1);
      tick(); chk_pc("retC", 16'd201, 1'b1);
      tick(); chk_pc("retB", 16'd101, 1'b1);
      tick(); chk_pc("retA", 16'h1001, 1'b1);
      chk("retA.ovf", 32'(ras_overflow), 32'd1);

      // Illegal mode encoding behaves as SEQ
      mode = 3'd6;
      tick(); chk_pc("illegal6", 16'h1002, 1'b0);

      // Stall holds state but table writes proceed; reset overrides stall
      mode = CALL; label_idx = 4'd1;
      tick(); chk_pc("call_pre", 16'd19, 1'b1);
      stall = 1'b1; mode = JABS; abs_target = 16'h1234;
      lbl_we = 1'b1; lbl_waddr = 4'd9; lbl_wdata = 16'h0555;
      tick(); chk_pc("stall", 16'd19, 1'b1);
      stall = 1'b0; lbl_we = 1'b0; mode = JLBL; label_idx = 4'd9;
      tick(); chk_pc("jlbl9", 16'h0555, 1'b1);
      stall = 1'b1; reset = 1'b1; mode = JABS;
      tick(); chk_pc("rst_stall", 16'h0000, 1'b0);
      chk("rst_stall.ovf", 32'(ras_overflow), 32'd0);
      chk("rst_stall.unf", 32'(ras_underflow), 32'd0);
      reset = 1'b0; stall = 1'b0; mode = JLBL; label_idx = 4'd9;
      tick(); chk_pc("tbl_clr", 16'h0000, 1'b1);
      mode = RET;
      tick(); chk_pc("ras_clr", 16'h0001, 1'b0);
      chk("ras_clr.unf", 32'(ras_underflow), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
